// File: rtl/oqpsk_pkg.sv
// Shared constants and helpers for the OQPSK modulator: mode encoding,
// bit-to-sign mapping and pulse-table index sizing.
package oqpsk_pkg;

  localparam logic [1:0] MODE_RECT = 2'd0;
  localparam logic [1:0] MODE_HSIN = 2'd1;
  localparam logic [1:0] MODE_RCW  = 2'd2;

  // Bit value that maps to the positive pulse polarity.
  localparam logic BIT_POS = 1'b1;

  // Checked-in base tables cover one half-symbol in 16 entries.
  localparam int BASE_IDX_W = 4;

  // Index width into a half-symbol of an SPS-sample pulse (pulses are symmetric).
  function automatic int tbl_idx_w(input int sps);
    return $clog2(sps) - 1;
  endfunction

endpackage

// File: rtl/oqpsk_pulse_rom.sv
// Combinational pulse-shape lookup: (mode, phase) -> unsigned amplitude <= MAX.
// Tables are the team-script output for SPS=32, OUT_W=12; other sizes resample/rescale them.
module oqpsk_pulse_rom
  import oqpsk_pkg::*;
#(
  parameter int OUT_W = 12,
  parameter int SPS   = 32,
  parameter int PH_W  = $clog2(SPS)
) (
  input  logic [1:0]       mode,
  input  logic [PH_W-1:0]  phase,
  output logic [OUT_W-2:0] amp
);

  localparam int HW = tbl_idx_w(SPS);

  logic [HW-1:0]         k_half;
  logic [BASE_IDX_W-1:0] base_idx;
  logic [10:0]           base_amp;
  logic [OUT_W-2:0]      scaled;

  function automatic logic [10:0] hsin_lut(input logic [3:0] i);
    case (i)
      4'd0:  return 11'd100;
      4'd1:  return 11'd300;
      4'd2:  return 11'd497;
      4'd3:  return 11'd690;
      4'd4:  return 11'd875;
      4'd5:  return 11'd1052;
      4'd6:  return 11'd1219;
      4'd7:  return 11'd1375;
      4'd8:  return 11'd1517;
      4'd9:  return 11'd1644;
      4'd10: return 11'd1756;
      4'd11: return 11'd1850;
      4'd12: return 11'd1927;
      4'd13: return 11'd1986;
      4'd14: return 11'd2025;
      default: return 11'd2045;
    endcase
  endfunction

  function automatic logic [10:0] rcw_lut(input logic [3:0] i);
    case (i)
      4'd0:  return 11'd5;
      4'd1:  return 11'd44;
      4'd2:  return 11'd121;
      4'd3:  return 11'd232;
      4'd4:  return 11'd374;
      4'd5:  return 11'd541;
      4'd6:  return 11'd726;
      4'd7:  return 11'd923;
      4'd8:  return 11'd1124;
      4'd9:  return 11'd1321;
      4'd10: return 11'd1506;
      4'd11: return 11'd1673;
      4'd12: return 11'd1815;
      4'd13: return 11'd1926;
      4'd14: return 11'd2003;
      default: return 11'd2042;
    endcase
  endfunction

  // Second half of the symbol mirrors the first.
  assign k_half = phase[PH_W-1] ? ~phase[HW-1:0] : phase[HW-1:0];

  generate
    if (HW >= BASE_IDX_W) begin : g_idx_dec
      assign base_idx = k_half[HW-1 -: BASE_IDX_W];
    end else begin : g_idx_exp
      assign base_idx = {k_half, {(BASE_IDX_W-HW){1'b0}}};
    end

    if (OUT_W == 12) begin : g_amp_eq
      assign scaled = base_amp;
    end else if (OUT_W > 12) begin : g_amp_up
      assign scaled = {base_amp, {(OUT_W-12){1'b0}}};
    end else begin : g_amp_dn
      assign scaled = base_amp[10 -: (OUT_W-1)];
    end
  endgenerate

  always_comb begin
    base_amp = 11'h7ff;
    amp      = {(OUT_W-1){1'b1}};
    case (mode)
      MODE_HSIN: begin
        base_amp = hsin_lut(base_idx);
        amp      = scaled;
      end
      MODE_RCW: begin
        base_amp = rcw_lut(base_idx);
        amp      = scaled;
      end
      MODE_RECT: amp = {(OUT_W-1){1'b1}};
      default:   amp = {(OUT_W-1){1'b1}};
    endcase
  end

endmodule

// File: rtl/oqpsk_shaper.sv
// OQPSK baseband modulator: bit FIFO, phase counter, I/Q rail registers with
// half-symbol Q offset, per-rail pulse shaping and registered I/Q outputs.
module oqpsk_shaper
  import oqpsk_pkg::*;
#(
  parameter int OUT_W = 12,
  parameter int SPS   = 32,
  parameter int PH_W  = $clog2(SPS),
  parameter int DEPTH = 4
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    EN,
  input  logic                    SMP_EN,
  input  logic [1:0]              MODE,
  input  logic                    BIT_IN,
  input  logic                    BIT_VALID,
  output logic                    BIT_READY,
  output logic signed [OUT_W-1:0] I_OUT,
  output logic signed [OUT_W-1:0] Q_OUT,
  output logic [PH_W-1:0]         PHASE,
  output logic                    SMP_VALID,
  output logic                    UNDERRUN
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0]   FULL = CW'(DEPTH);
  localparam logic [PH_W-1:0] HALF = PH_W'(SPS / 2);

  logic              fifo_mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              ready_q, ready_d;
  logic [PH_W-1:0]   cnt_q, cnt_d, q_phase;
  logic              i_bit_q, i_bit_d, q_bit_q, q_bit_d;
  logic              i_idle_q, i_idle_d, q_idle_q, q_idle_d;
  logic [1:0]        i_mode_q, i_mode_d, q_mode_q, q_mode_d;
  logic signed [OUT_W-1:0] i_out_q, i_out_d, q_out_q, q_out_d;
  logic [PH_W-1:0]   phase_q, phase_d;
  logic              smp_valid_q, smp_valid_d, underrun_q, underrun_d;

  logic              step, fifo_empty, i_load, q_load, push, pop, head;
  logic [OUT_W-2:0]  i_amp, q_amp;

  function automatic logic signed [OUT_W-1:0] map_sample(input logic idle, input logic b,
                                                         input logic [OUT_W-2:0] amp);
    logic signed [OUT_W-1:0] mag;
    mag = signed'({1'b0, amp});
    if (idle) return '0;
    return (b == BIT_POS) ? mag : -mag;
  endfunction

  assign q_phase = cnt_q ^ HALF;

  oqpsk_pulse_rom #(.OUT_W(OUT_W), .SPS(SPS), .PH_W(PH_W)) u_rom_i (
    .mode (i_mode_d),
    .phase(cnt_q),
    .amp  (i_amp)
  );

  oqpsk_pulse_rom #(.OUT_W(OUT_W), .SPS(SPS), .PH_W(PH_W)) u_rom_q (
    .mode (q_mode_d),
    .phase(q_phase),
    .amp  (q_amp)
  );

  always_comb begin
    step       = SMP_EN & EN;
    fifo_empty = (count_q == '0);
    i_load     = step && (cnt_q == '0);
    q_load     = step && (cnt_q == HALF);
    push       = BIT_VALID & ready_q;
    // Empty is judged on the registered count, so a same-cycle push never bypasses.
    pop        = (i_load | q_load) & ~fifo_empty;
    head       = fifo_mem_q[rd_ptr_q];

    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    ready_d = (count_d != FULL);

    i_bit_d  = i_bit_q;
    q_bit_d  = q_bit_q;
    i_idle_d = i_idle_q;
    q_idle_d = q_idle_q;
    i_mode_d = i_mode_q;
    q_mode_d = q_mode_q;
    if (!EN) begin
      i_idle_d = 1'b1;
      q_idle_d = 1'b1;
    end else if (i_load) begin
      i_bit_d  = head;
      i_idle_d = fifo_empty;
      i_mode_d = MODE;
    end else if (q_load) begin
      q_bit_d  = head;
      q_idle_d = fifo_empty;
      q_mode_d = MODE;
    end

    cnt_d = cnt_q;
    if (!EN)       cnt_d = '0;
    else if (step) cnt_d = cnt_q + PH_W'(1);

    i_out_d     = i_out_q;
    q_out_d     = q_out_q;
    phase_d     = phase_q;
    smp_valid_d = step;
    underrun_d  = (i_load | q_load) & fifo_empty;
    if (!EN) begin
      i_out_d = '0;
      q_out_d = '0;
      phase_d = '0;
    end else if (step) begin
      i_out_d = map_sample(i_idle_d, i_bit_d, i_amp);
      q_out_d = map_sample(q_idle_d, q_bit_d, q_amp);
      phase_d = cnt_q;
    end
  end

  always_ff @(posedge CLK) begin
    if (push) fifo_mem_q[wr_ptr_q] <= BIT_IN;
    i_bit_q <= i_bit_d;
    q_bit_q <= q_bit_d;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      ready_q     <= 1'b1;
      cnt_q       <= '0;
      i_idle_q    <= 1'b1;
      q_idle_q    <= 1'b1;
      i_mode_q    <= MODE_RECT;
      q_mode_q    <= MODE_RECT;
      i_out_q     <= '0;
      q_out_q     <= '0;
      phase_q     <= '0;
      smp_valid_q <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      ready_q     <= ready_d;
      cnt_q       <= cnt_d;
      i_idle_q    <= i_idle_d;
      q_idle_q    <= q_idle_d;
      i_mode_q    <= i_mode_d;
      q_mode_q    <= q_mode_d;
      i_out_q     <= i_out_d;
      q_out_q     <= q_out_d;
      phase_q     <= phase_d;
      smp_valid_q <= smp_valid_d;
      underrun_q  <= underrun_d;
    end
  end

  assign BIT_READY = ready_q;
  assign I_OUT     = i_out_q;
  assign Q_OUT     = q_out_q;
  assign PHASE     = phase_q;
  assign SMP_VALID = smp_valid_q;
  assign UNDERRUN  = underrun_q;

endmodule

// File: tb/tb_oqpsk_shaper.sv
// Scoreboard bench for oqpsk_shaper: a queue/formula reference model predicts each
// presented sample; a negedge monitor pops and compares against the DUT.
module tb_oqpsk_shaper;

  localparam int  OUT_W = 12;
  localparam int  SPS   = 32;
  localparam int  PH_W  = 5;
  localparam int  DEPTH = 4;
  localparam int  MAX   = 2047;
  localparam real PI    = 3.14159265358979;

  logic clk = 1'b0;
  logic rst = 1'b1, en = 1'b0, smp_en = 1'b0, bit_in = 1'b0, bit_valid = 1'b0;
  logic [1:0] mode = 2'd0;
  logic bit_ready, smp_valid, underrun;
  logic signed [OUT_W-1:0] i_out, q_out;
  logic [PH_W-1:0] phase;

  always #5 clk = ~clk;

  oqpsk_shaper #(.OUT_W(OUT_W), .SPS(SPS), .PH_W(PH_W), .DEPTH(DEPTH)) dut (
    .CLK(clk), .RST(rst), .EN(en), .SMP_EN(smp_en), .MODE(mode),
    .BIT_IN(bit_in), .BIT_VALID(bit_valid), .BIT_READY(bit_ready),
    .I_OUT(i_out), .Q_OUT(q_out), .PHASE(phase),
    .SMP_VALID(smp_valid), .UNDERRUN(underrun)
  );

  typedef struct {
    int i;
    int q;
    int ph;
    bit und;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  bit   chk_en = 1'b0;
  bit   exp_ready, exp_zero;

  // Reference state: FIFO contents, sample counter, and the symbol on each rail.
  bit   mq[$];
  int   m_cnt;
  bit   ri_idle, ri_b, rq_idle, rq_b;
  int   ri_mode, rq_mode;

  function automatic int pulse(input int m, input int k);
    real a, x;
    a = (real'(k) + 0.5) / real'(SPS);
    case (m)
      1: x = MAX * $sin(PI * a);
      2: x = MAX * (1.0 - $cos(2.0 * PI * a)) / 2.0;
      default: return MAX;
    endcase
    return $rtoi(x + 0.5);
  endfunction

  function automatic int shape(input bit idle, input bit b, input int m, input int k);
    if (idle) return 0;
    return b ? pulse(m, k) : -pulse(m, k);
  endfunction

  task automatic fail(input string name, input int got, input int want);
    bad++;
    $display("FAIL %s got=%0d expected=%0d at %0t", name, got, want, $time);
  endtask

  task automatic cyc(input bit r, input bit e, input bit s, input bit [1:0] m,
                     input bit bv, input bit bi);
    bit   psh, und;
    exp_t ex;
    @(negedge clk);
    #1;
    rst = r; en = e; smp_en = s; mode = m; bit_valid = bv; bit_in = bi;
    chk_en = 1'b1;
    if (r) begin
      mq.delete();
      m_cnt = 0;
      ri_idle = 1; rq_idle = 1; ri_mode = 0; rq_mode = 0;
      exp_ready = 1; exp_zero = 1;
      return;
    end
    psh = bv && (mq.size() < DEPTH);
    und = 0;
    exp_zero = !e;
    if (!e) begin
      m_cnt = 0;
      ri_idle = 1;
      rq_idle = 1;
    end else if (s) begin
      if (m_cnt == 0) begin
        if (mq.size() == 0) begin ri_idle = 1; und = 1; end
        else begin ri_b = mq.pop_front(); ri_idle = 0; end
        ri_mode = m;
      end
      if (m_cnt == SPS / 2) begin
        if (mq.size() == 0) begin rq_idle = 1; und = 1; end
        else begin rq_b = mq.pop_front(); rq_idle = 0; end
        rq_mode = m;
      end
      ex.i   = shape(ri_idle, ri_b, ri_mode, m_cnt);
      ex.q   = shape(rq_idle, rq_b, rq_mode, (m_cnt + SPS / 2) % SPS);
      ex.ph  = m_cnt;
      ex.und = und;
      sb.push_back(ex);
      m_cnt = (m_cnt + 1) % SPS;
    end
    if (psh) mq.push_back(bi);
    exp_ready = (mq.size() < DEPTH);
  endtask

  exp_t e_mon;
  always @(negedge clk) begin
    if (chk_en) begin
      total++;
      if (bit_ready !== exp_ready) fail("bit_ready", int'(bit_ready), int'(exp_ready));
      if (exp_zero) begin
        total++;
        if (i_out !== '0 || q_out !== '0 || phase !== '0 || smp_valid !== 1'b0 || underrun !== 1'b0)
          fail("idle_outputs_nonzero_i", int'(i_out), 0);
      end
      if (smp_valid === 1'b1 || sb.size() > 0) begin
        total++;
        if (sb.size() == 0) fail("unexpected_smp_valid", int'(smp_valid), 0);
        else begin
          e_mon = sb.pop_front();
          if (smp_valid !== 1'b1)              fail("smp_valid", int'(smp_valid), 1);
          else if (int'(i_out) != e_mon.i)     fail("i_out", int'(i_out), e_mon.i);
          else if (int'(q_out) != e_mon.q)     fail("q_out", int'(q_out), e_mon.q);
          else if (int'(phase) != e_mon.ph)    fail("phase", int'(phase), e_mon.ph);
          else if (underrun !== e_mon.und)     fail("underrun", int'(underrun), int'(e_mon.und));
        end
      end else begin
        total++;
        if (underrun !== 1'b0) fail("underrun_without_valid", int'(underrun), 0);
      end
    end
  end

  initial begin
    // Reset state
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);

    // Rect: bits 1,0 then two full symbols (I underruns on the second)
    cyc(0, 0, 0, 0, 1, 1);
    cyc(0, 0, 0, 0, 1, 0);
    for (int k = 0; k < 2 * SPS; k++) cyc(0, 1, 1, 0, 0, 0);

    // Half-sine, all-ones stream kept topped up
    cyc(1, 0, 0, 0, 0, 0);
    for (int k = 0; k < 4 * SPS; k++) cyc(0, 1, 1, 1, 1, 1);

    // Raised-cosine with bit 0, then MODE switched to rect at phase 5
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 2, 1, 0);
    cyc(0, 0, 0, 2, 1, 1);
    for (int k = 0; k < 5; k++) cyc(0, 1, 1, 2, 0, 0);
    for (int k = 0; k < 2 * SPS; k++) cyc(0, 1, 1, 0, 1, 0);

    // Underrun: single bit, run two symbols
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 1);
    for (int k = 0; k < 2 * SPS + 2; k++) cyc(0, 1, 1, 0, 0, 0);

    // Backpressure: fill with EN=0, then hold BIT_VALID while running
    cyc(1, 0, 0, 0, 0, 0);
    for (int k = 0; k < 7; k++) cyc(0, 0, 1, 0, 1, 1'($urandom));
    for (int k = 0; k < 3 * SPS; k++) cyc(0, 1, 1, 1, 1, 1'($urandom));

    // Reset at phase 9, then EN drop at phase 20 and restart
    cyc(1, 0, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) cyc(0, 0, 0, 0, 1, 1'($urandom));
    for (int k = 0; k < 9; k++) cyc(0, 1, 1, 2, 1, 1'($urandom));
    cyc(1, 1, 1, 2, 1, 1);
    for (int k = 0; k < 3; k++) cyc(0, 0, 0, 0, 1, 1'($urandom));
    for (int k = 0; k < 20; k++) cyc(0, 1, 1, 1, 1, 1'($urandom));
    for (int k = 0; k < 3; k++) cyc(0, 0, 1, 1, 0, 0);
    for (int k = 0; k < SPS + 4; k++) cyc(0, 1, 1, 2, 1, 1'($urandom));

    // Fully random traffic
    for (int k = 0; k < 3000; k++)
      cyc(($urandom % 400) == 0, ($urandom % 25) != 0, ($urandom % 4) != 0,
          2'($urandom), ($urandom % 3) != 0, 1'($urandom));

    cyc(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    total++;
    if (sb.size() != 0) fail("scoreboard_leftover", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/oqpsk_shaper.md
# oqpsk_shaper

Parametrised OQPSK baseband modulator and successor of the fixed single-rail raised-cosine shaper. It accepts a serial bit stream through a valid/ready handshake and buffers it in a small FIFO. Bits are split alternately onto I and Q rails, with Q offset by half a symbol, and each symbol is shaped with a run-time selectable pulse (rectangular, half-sine or raised-cosine window). It sits between the user-area bit source (GPIO or Wishbone-fed) and the pad-level DAC outputs, and produces signed I/Q samples plus a phase index.

## Interface
- `OUT_W`, 12: signed sample width. Peak amplitude `MAX` = 2^(OUT_W-1)-1.
- `SPS`, 32: samples per rail symbol. Power of two, ≥4.
- `PH_W`, $clog2(SPS): phase index width.
- `DEPTH`, 4: bit FIFO depth. Power of two, ≥2.

Ports:
- `CLK` in 1: single clock.
- `RST` in 1: reset, synchronous and active-high.
- `EN` in 1: run enable.
- `SMP_EN` in 1: sample-rate strobe, one cycle per output sample.
- `MODE` in 2: pulse select. 0 rect, 1 half-sine, 2 raised-cosine window, 3 treated as 0.
- `BIT_IN` in 1: data bit.
- `BIT_VALID` in 1: `BIT_IN` valid.
- `BIT_READY` out 1: FIFO not full.
- `I_OUT` out OUT_W: signed I sample.
- `Q_OUT` out OUT_W: signed Q sample.
- `PHASE` out PH_W: I-rail phase index of the current output sample.
- `SMP_VALID` out 1: one-cycle pulse when new I/Q are presented.
- `UNDERRUN` out 1: one-cycle pulse when a rail load finds the FIFO empty.

## Operation
- **FIFO.** A push occurs when `BIT_VALID && BIT_READY`. `BIT_READY` = !full, registered from the occupancy count. A push while full is impossible because ready is low. Push and pop in the same cycle are allowed; the count is unchanged and the pop returns the older entry. There is no bypass: a pop from an empty FIFO underruns even if a push happens in the same cycle.
- **Phase counter `cnt`** (PH_W bits):
  - Advances by 1 mod SPS on each `SMP_EN` while `EN`=1.
  - Is held at 0 while `EN`=0.
  - Q phase = cnt XOR (SPS/2), i.e. the MSB inverted.
- **Rail loads**, on an `SMP_EN` with `EN`=1:
  - cnt==0: pop one bit into the I rail and latch `MODE` into the I-rail mode register.
  - cnt==SPS/2: pop one bit into the Q rail and latch the Q-rail mode.
  - Mode changes therefore take effect only at that rail's symbol boundary.
- **Mapping.** Bit 1 maps to +p and bit 0 to −p. If the FIFO is empty at a load, the rail is marked idle (amplitude 0) for that whole symbol and `UNDERRUN` pulses.
- **Pulse table.** p[k] for k=0..SPS-1, unsigned, ≤MAX.
  - Rect: p=MAX.
  - Half-sine: round(MAX·sin(π(k+0.5)/SPS)).
  - RC window: round(MAX·(1−cos(2π(k+0.5)/SPS))/2).
- **Sample arithmetic.** Samples are formed in two's complement as +p or −p. Negation never overflows because p ≤ MAX.
- **Reset and idle.** After reset both rails are idle. Q stays idle until its first load.
- **EN=0.** Outputs are forced to 0 and `SMP_VALID` stays low. Rail state is idled, so a restart begins with a fresh I load at cnt 0. The FIFO keeps accepting bits and is not flushed.

## Timing
- Reset values: `I_OUT`=0, `Q_OUT`=0, `PHASE`=0, `SMP_VALID`=0, `UNDERRUN`=0, `BIT_READY`=1 in the cycle after reset. FIFO is empty, cnt=0, both rails idle, both mode registers 0.
- Latency: an `SMP_EN` in cycle t presents samples for the pre-increment cnt in cycle t+1, with `SMP_VALID`=1. A load at cnt==0 affects the sample presented at t+1.
- `UNDERRUN` is asserted in the same cycle as the corresponding `SMP_VALID`.
- Bit throughput: 2 bits per SPS samples. For a sustained stream the source must sustain at least that rate.
- `RST` mid-operation has priority over all inputs. The next cycle shows the reset state and any in-flight bits are discarded.
- Back-to-back `SMP_EN` on consecutive cycles is supported. `SMP_EN` while `EN`=0 is ignored.

## Structure
- Package `oqpsk_pkg` holds:
  - the mode encoding constants (MODE_RECT, MODE_HSIN, MODE_RCW);
  - the bit-to-sign mapping constant;
  - the table-index width function.
- Sub-module `oqpsk_pulse_rom`:
  - (mode, phase) → p. Purely combinational and instantiated twice, once per rail.
  - Contents are generated offline by the team table script for each (SPS, OUT_W) pair and checked in. Defaults are SPS=32, OUT_W=12.
- FIFO, counter, rail registers and output registers live in the top level.

## Test plan
- **Rect mode, I/Q mapping and offset.** MODE=0, `EN`=1, push bits 1,0, `SMP_EN` every cycle → `I_OUT`=+2047 for PHASE 0..31. `Q_OUT`=0 for the first 16 samples, then −2047 from PHASE 16.
- **Half-sine amplitudes.** MODE=1, bit stream all 1s → I samples at PHASE 0, 15, 16, 31 = 100, 2045, 2045, 100. `Q_OUT` at PHASE 16 = 100.
- **Raised-cosine window and mode latching.** MODE=2, bit 0 → I at PHASE 0 = −5, at PHASE 16 = −2042. Switching MODE to 0 at PHASE 5 takes effect only at the next cnt==0.
- **Underrun.** A single bit is pushed → Q load at PHASE 16 gives `UNDERRUN` pulse and `Q_OUT`=0 for 32 samples. `UNDERRUN` pulses again at the next I load.
- **Backpressure.** Push 4 bits with `EN`=0 → `BIT_READY`=0 after the 4th. A held `BIT_VALID` is not consumed until the first pop, then ready rises for one push.
- **Reset mid-symbol and EN toggle.** Assert `RST` at PHASE 9 → next cycle all outputs 0, `BIT_READY`=1, FIFO empty. Drop `EN` at PHASE 20 → outputs 0. Re-raise `EN` → the first sample has PHASE=0 and a fresh I load.
